alu_issue: RTL and testbench

- ID/EX issue stage feeding the ALU.
- Decodes the ID-stage instruction into ALU opcode and operands, and registers them into the ID/EX pipeline register under stall/flush control.
- Resolves branches in EX from the ALU compare flags returned on the same cycle.
- Sits between the register file/decode logic and the ALU.

---
 rtl/alu_issue.sv | 182 ++++++++++++++++++
 tb/tb_alu_issue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ID/EX issue stage: decode to ALU op/operands, pipeline register, branch resolve
module alu_issue #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc4,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            stall,
    input  logic            flush,
    input  logic            beq_sig,
    input  logic            bne_sig,
    input  logic            bgez_sig,
    input  logic            bgtz_sig,
    input  logic            blez_sig,
    input  logic            bltz_sig,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_alu_a,
    output logic [XLEN-1:0] ex_alu_b,
    output logic [OPW-1:0]  ex_alu_op,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_illegal,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target
);

    localparam logic [OPW-1:0] ALU_NOP  = OPW'(0);
    localparam logic [OPW-1:0] ALU_ADD  = OPW'(1);
    localparam logic [OPW-1:0] ALU_SUB  = OPW'(2);
    localparam logic [OPW-1:0] ALU_AND  = OPW'(3);
    localparam logic [OPW-1:0] ALU_OR   = OPW'(4);
    localparam logic [OPW-1:0] ALU_XOR  = OPW'(5);
    localparam logic [OPW-1:0] ALU_NOR  = OPW'(6);
    localparam logic [OPW-1:0] ALU_SLT  = OPW'(7);
    localparam logic [OPW-1:0] ALU_SLTU = OPW'(8);
    localparam logic [OPW-1:0] ALU_SLL  = OPW'(9);
    localparam logic [OPW-1:0] ALU_SRA  = OPW'(10);
    localparam logic [OPW-1:0] ALU_SRL  = OPW'(11);
    localparam logic [OPW-1:0] ALU_LUI  = OPW'(12);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BGEZ = 3'd5,
        BR_BLTZ = 3'd6
    } br_t;

    logic [5:0]      opc, funct;
    logic [4:0]      rt_f, rd_f, shamt;
    logic [15:0]     imm;
    logic [XLEN-1:0] imm_s, imm_z, shamt_z;

    assign opc     = id_instr[31:26];
    assign rt_f    = id_instr[20:16];
    assign rd_f    = id_instr[15:11];
    assign shamt   = id_instr[10:6];
    assign funct   = id_instr[5:0];
    assign imm     = id_instr[15:0];
    assign imm_s   = {{(XLEN-16){imm[15]}}, imm};
    assign imm_z   = {{(XLEN-16){1'b0}}, imm};
    assign shamt_z = {{(XLEN-5){1'b0}}, shamt};

    logic [XLEN-1:0] d_a, d_b, d_tgt;
    logic [OPW-1:0]  d_op;
    logic [4:0]      d_rd;
    logic            d_wr, d_ill;
    br_t             d_br, ex_br;

    always_comb begin
        d_a   = rs_data;
        d_b   = rt_data;
        d_op  = ALU_NOP;
        d_rd  = 5'd0;
        d_wr  = 1'b0;
        d_ill = 1'b0;
        d_br  = BR_NONE;
        d_tgt = '0;
        case (opc)
            6'h00: begin
                d_rd = rd_f;
                d_wr = 1'b1;
                case (funct)
                    6'h20, 6'h21: d_op = ALU_ADD;
                    6'h22, 6'h23: d_op = ALU_SUB;
                    6'h24:        d_op = ALU_AND;
                    6'h25:        d_op = ALU_OR;
                    6'h26:        d_op = ALU_XOR;
                    6'h27:        d_op = ALU_NOR;
                    6'h2A:        d_op = ALU_SLT;
                    6'h2B:        d_op = ALU_SLTU;
                    6'h00: begin d_op = ALU_SLL; d_a = shamt_z; end
                    6'h03: begin d_op = ALU_SRA; d_a = shamt_z; end
                    6'h02: begin d_op = ALU_SRL; d_a = shamt_z; end
                    6'h04:        d_op = ALU_SLL;
                    6'h07:        d_op = ALU_SRA;
                    6'h06:        d_op = ALU_SRL;
                    default:      d_ill = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin d_op = ALU_ADD;  d_b = imm_s; d_rd = rt_f; d_wr = 1'b1; end
            6'h0A:        begin d_op = ALU_SLT;  d_b = imm_s; d_rd = rt_f; d_wr = 1'b1; end
            6'h0B:        begin d_op = ALU_SLTU; d_b = imm_s; d_rd = rt_f; d_wr = 1'b1; end
            6'h0C:        begin d_op = ALU_AND;  d_b = imm_z; d_rd = rt_f; d_wr = 1'b1; end
            6'h0D:        begin d_op = ALU_OR;   d_b = imm_z; d_rd = rt_f; d_wr = 1'b1; end
            6'h0E:        begin d_op = ALU_XOR;  d_b = imm_z; d_rd = rt_f; d_wr = 1'b1; end
            6'h0F:        begin d_op = ALU_LUI;  d_b = imm_z; d_a = '0; d_rd = rt_f; d_wr = 1'b1; end
            6'h04:        begin d_op = ALU_SUB;  d_br = BR_BEQ;  end
            6'h05:        begin d_op = ALU_SUB;  d_br = BR_BNE;  end
            6'h06:        begin d_op = ALU_SUB;  d_br = BR_BLEZ; end
            6'h07:        begin d_op = ALU_SUB;  d_br = BR_BGTZ; end
            6'h01: begin
                if (rt_f == 5'd1) begin
                    d_op = ALU_SUB;
                    d_br = BR_BGEZ;
                end else if (rt_f == 5'd0) begin
                    d_op = ALU_SUB;
                    d_br = BR_BLTZ;
                end else begin
                    d_ill = 1'b1;
                end
            end
            default: d_ill = 1'b1;
        endcase
        // Illegal slots travel down the pipe as inert NOPs carrying only the flag
        if (d_ill) begin
            d_a  = '0;
            d_b  = '0;
            d_op = ALU_NOP;
            d_rd = 5'd0;
            d_wr = 1'b0;
        end
        if (d_br != BR_NONE)
            d_tgt = id_pc4 + (imm_s << 2);
        if (d_rd == 5'd0)
            d_wr = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush || (!stall && !id_valid)) begin
            ex_valid      <= 1'b0;
            ex_alu_a      <= '0;
            ex_alu_b      <= '0;
            ex_alu_op     <= ALU_NOP;
            ex_rd         <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_illegal    <= 1'b0;
            ex_br         <= BR_NONE;
            branch_target <= '0;
        end else if (!stall) begin
            ex_valid      <= 1'b1;
            ex_alu_a      <= d_a;
            ex_alu_b      <= d_b;
            ex_alu_op     <= d_op;
            ex_rd         <= d_rd;
            ex_reg_write  <= d_wr;
            ex_illegal    <= d_ill;
            ex_br         <= d_br;
            branch_target <= d_tgt;
        end
    end

    always_comb begin
        case (ex_br)
            BR_BEQ:  branch_taken = ex_valid & beq_sig;
            BR_BNE:  branch_taken = ex_valid & bne_sig;
            BR_BLEZ: branch_taken = ex_valid & blez_sig;
            BR_BGTZ: branch_taken = ex_valid & bgtz_sig;
            BR_BGEZ: branch_taken = ex_valid & bgez_sig;
            BR_BLTZ: branch_taken = ex_valid & bltz_sig;
            default: branch_taken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr, id_pc4, rs_data, rt_data;
    logic        stall, flush;
    logic        beq_sig, bne_sig, bgez_sig, bgtz_sig, blez_sig, bltz_sig;
    logic        ex_valid, ex_reg_write, ex_illegal, branch_taken;
    logic [31:0] ex_alu_a, ex_alu_b, branch_target;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd;

    int total = 0;
    int bad   = 0;

    alu_issue #(.XLEN(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc4(id_pc4), .rs_data(rs_data), .rt_data(rt_data),
        .stall(stall), .flush(flush),
        .beq_sig(beq_sig), .bne_sig(bne_sig), .bgez_sig(bgez_sig),
        .bgtz_sig(bgtz_sig), .blez_sig(blez_sig), .bltz_sig(bltz_sig),
        .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
        .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_illegal(ex_illegal), .branch_taken(branch_taken),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
        chk({tag, ".op"}, 32'(ex_alu_op), 32'd0);
        chk({tag, ".a"}, ex_alu_a, 32'd0);
        chk({tag, ".b"}, ex_alu_b, 32'd0);
        chk({tag, ".rd"}, 32'(ex_rd), 32'd0);
        chk({tag, ".wr"}, 32'(ex_reg_write), 32'd0);
        chk({tag, ".ill"}, 32'(ex_illegal), 32'd0);
        chk({tag, ".taken"}, 32'(branch_taken), 32'd0);
        chk({tag, ".tgt"}, branch_target, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc4 = '0;
        rs_data = '0; rt_data = '0; stall = 1'b0; flush = 1'b0;
        beq_sig = 1'b0; bne_sig = 1'b0; bgez_sig = 1'b0;
        bgtz_sig = 1'b0; blez_sig = 1'b0; bltz_sig = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ADDU r3, r1, r2
        id_valid = 1'b1; id_instr = 32'h00221821; rs_data = 32'd5; rt_data = 32'd7;
        step();
        chk("addu.valid", 32'(ex_valid), 32'd1);
        chk("addu.op", 32'(ex_alu_op), 32'd1);
        chk("addu.a", ex_alu_a, 32'd5);
        chk("addu.b", ex_alu_b, 32'd7);
        chk("addu.rd", 32'(ex_rd), 32'd3);
        chk("addu.wr", 32'(ex_reg_write), 32'd1);

        // SRA r2, r3, 2
        id_instr = 32'h00031083; rs_data = 32'h00001234; rt_data = 32'h80000000;
        step();
        chk("sra.op", 32'(ex_alu_op), 32'd10);
        chk("sra.a", ex_alu_a, 32'd2);
        chk("sra.b", ex_alu_b, 32'h80000000);
        chk("sra.rd", 32'(ex_rd), 32'd2);

        // ORI r2, r1, 0xFFFF
        id_instr = 32'h3422FFFF; rs_data = 32'h00000011;
        step();
        chk("ori.op", 32'(ex_alu_op), 32'd4);
        chk("ori.a", ex_alu_a, 32'h00000011);
        chk("ori.b", ex_alu_b, 32'h0000FFFF);
        chk("ori.rd", 32'(ex_rd), 32'd2);

        // LUI r1, 0x1234
        id_instr = 32'h3C011234; rs_data = 32'h00000099;
        step();
        chk("lui.op", 32'(ex_alu_op), 32'd12);
        chk("lui.a", ex_alu_a, 32'd0);
        chk("lui.b", ex_alu_b, 32'h00001234);
        chk("lui.wr", 32'(ex_reg_write), 32'd1);

        // BEQ r1, r2, -1 from pc4=0x100
        id_instr = 32'h1022FFFF; id_pc4 = 32'h100; rs_data = 32'd3; rt_data = 32'd3;
        beq_sig = 1'b1;
        step();
        chk("beq.taken", 32'(branch_taken), 32'd1);
        chk("beq.tgt", branch_target, 32'h000000FC);
        chk("beq.wr", 32'(ex_reg_write), 32'd0);
        chk("beq.op", 32'(ex_alu_op), 32'd2);
        beq_sig = 1'b0; bne_sig = 1'b1;
        #1;
        chk("beq.nottaken", 32'(branch_taken), 32'd0);
        bne_sig = 1'b0; beq_sig = 1'b1;

        // Stall three cycles with a changing ID instruction
        stall = 1'b1; id_instr = 32'h00221821;
        for (int i = 0; i < 3; i++) begin
            step();
            id_instr = 32'h3C01AAAA + 32'(i);
            chk("stall.op", 32'(ex_alu_op), 32'd2);
            chk("stall.tgt", branch_target, 32'h000000FC);
            chk("stall.taken", 32'(branch_taken), 32'd1);
        end

        // Flush beats stall
        flush = 1'b1;
        step();
        chk_all_zero("flush");
        flush = 1'b0; stall = 1'b0;

        // BGEZ r1, +4 from pc4=0x200
        id_instr = 32'h04210004; id_pc4 = 32'h200; beq_sig = 1'b0; bgez_sig = 1'b1;
        step();
        chk("bgez.taken", 32'(branch_taken), 32'd1);
        chk("bgez.tgt", branch_target, 32'h00000210);
        bgez_sig = 1'b0;

        // Undecodable opcode
        id_instr = 32'hFC000000;
        step();
        chk("ill.flag", 32'(ex_illegal), 32'd1);
        chk("ill.wr", 32'(ex_reg_write), 32'd0);
        chk("ill.op", 32'(ex_alu_op), 32'd0);
        chk("ill.tgt", branch_target, 32'd0);

        // All-zero word issues as SLL r0
        id_instr = 32'h00000000;
        step();
        chk("nop.valid", 32'(ex_valid), 32'd1);
        chk("nop.wr", 32'(ex_reg_write), 32'd0);
        chk("nop.ill", 32'(ex_illegal), 32'd0);
        chk("nop.op", 32'(ex_alu_op), 32'd9);

        // Invalid ID slot loads a bubble
        id_valid = 1'b0; id_instr = 32'h00221821;
        step();
        chk_all_zero("bubble");

        // Asynchronous reset mid-stream
        id_valid = 1'b1; rs_data = 32'd5; rt_data = 32'd7;
        step();
        chk("pre_rst.valid", 32'(ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
